// File: rtl/bcd_entry_ctrl.sv
// ============================================================================
// bcd_entry_ctrl: 4-digit BCD keypad entry with iterative BCD-to-binary
// conversion (reverse double dabble, one step per cycle).
// Revision: 1.0
// ============================================================================
`default_nettype none

module bcd_entry_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  output logic [3:0]  thousands,
  output logic [3:0]  hundreds,
  output logic [3:0]  tens,
  output logic [3:0]  ones,
  output logic [2:0]  digit_count,
  output logic        busy,
  output logic [15:0] result,
  output logic        result_valid
);

  typedef enum logic [0:0] {
    ENTRY = 1'b0,
    CONV  = 1'b1
  } state_t;

  localparam logic [3:0] KEY_CLEAR = 4'hA;
  localparam logic [3:0] KEY_BKSP  = 4'hB;
  localparam logic [3:0] KEY_ENTER = 4'hC;

  state_t      state, state_n;
  logic [15:0] digits, digits_n;
  logic [2:0]  count, count_n;
  logic [31:0] shifter, shifter_n;
  logic [31:0] step;
  logic [3:0]  iter, iter_n;
  logic [15:0] result_n;
  logic        result_valid_n;

  // One reverse double-dabble step: shift right, then pull each BCD nibble
  // that reached 8 or more back down by 3.
  always_comb begin
    step = {1'b0, shifter[31:1]};
    for (int i = 0; i < 4; i++) begin
      if (step[16 + 4*i +: 4] >= 4'd8)
        step[16 + 4*i +: 4] = step[16 + 4*i +: 4] - 4'd3;
    end
  end

  always_comb begin
    state_n        = state;
    digits_n       = digits;
    count_n        = count;
    shifter_n      = shifter;
    iter_n         = iter;
    result_n       = result;
    result_valid_n = 1'b0;

    case (state)
      ENTRY: begin
        if (key_valid) begin
          if (key_code <= 4'd9) begin
            if (count < 3'd4) begin
              digits_n = {digits[11:0], key_code};
              count_n  = count + 3'd1;
            end
          end else if (key_code == KEY_CLEAR) begin
            digits_n = 16'h0;
            count_n  = 3'd0;
          end else if (key_code == KEY_BKSP) begin
            if (count != 3'd0) begin
              digits_n = {4'h0, digits[15:4]};
              count_n  = count - 3'd1;
            end
          end else if (key_code == KEY_ENTER) begin
            shifter_n = {digits, 16'h0};
            iter_n    = 4'd0;
            state_n   = CONV;
          end
        end
      end

      CONV: begin
        shifter_n = step;
        iter_n    = iter + 4'd1;
        if (iter == 4'd15) begin
          result_n       = step[15:0];
          result_valid_n = 1'b1;
          digits_n       = 16'h0;
          count_n        = 3'd0;
          state_n        = ENTRY;
        end
      end

      default: state_n = ENTRY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ENTRY;
      digits       <= 16'h0;
      count        <= 3'd0;
      shifter      <= 32'h0;
      iter         <= 4'd0;
      result       <= 16'h0;
      result_valid <= 1'b0;
    end else begin
      state        <= state_n;
      digits       <= digits_n;
      count        <= count_n;
      shifter      <= shifter_n;
      iter         <= iter_n;
      result       <= result_n;
      result_valid <= result_valid_n;
    end
  end

  assign thousands   = digits[15:12];
  assign hundreds    = digits[11:8];
  assign tens        = digits[7:4];
  assign ones        = digits[3:0];
  assign digit_count = count;
  assign busy        = (state == CONV);

endmodule

`default_nettype wire
